// File: rtl/frame_aligner_if.sv
// frame_aligner_if: descrambled word input and aligned frame output bundle for frame_aligner
interface frame_aligner_if;
  logic [61:0] rx_data;
  logic        rx_valid;
  logic [61:0] unscrambled_data;
  logic [4:0]  frame_state;
  logic        frame_tail_flag;
  logic        frame_lock;
  logic [15:0] marker_err_cnt;
  modport master (
    output rx_data, rx_valid,
    input  unscrambled_data, frame_state, frame_tail_flag, frame_lock, marker_err_cnt
  );
  modport slave (
    input  rx_data, rx_valid,
    output unscrambled_data, frame_state, frame_tail_flag, frame_lock, marker_err_cnt
  );
endinterface

// File: rtl/frame_aligner.sv
// frame_aligner: acquires and tracks 26-word superframe alignment and tags words with Gray-coded positions
module frame_aligner #(
  parameter logic [43:0] MARKER   = 44'hA5C_3F0F_96E1,
  parameter int          LOCK_CNT = 3,
  parameter int          MISS_CNT = 4
) (
  input logic             clk_390p625M,
  input logic             rst,
  frame_aligner_if.slave  bus
);
  localparam logic [2:0] LOCK_N = 3'(LOCK_CNT);
  localparam logic [2:0] MISS_N = 3'(MISS_CNT);
  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_e;
  state_e      state_q, state_d;
  logic [4:0]  pos_q, pos_d, fs_q, fs_d, pos_nx;
  logic [2:0]  good_q, good_d, miss_q, miss_d;
  logic [61:0] data_q, data_d;
  logic [15:0] err_q, err_d;
  logic        tail_q, tail_d, lock_q, match, at_tail;
  assign match   = bus.rx_data[43:0] == MARKER;
  assign at_tail = pos_q == 5'd26;
  assign pos_nx  = at_tail ? 5'd1 : pos_q + 5'd1;
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    good_d  = good_q;
    miss_d  = miss_q;
    err_d   = err_q;
    fs_d    = '0;
    tail_d  = 1'b0;
    data_d  = bus.rx_valid ? bus.rx_data : data_q;
    if (bus.rx_valid)
      case (state_q)
        HUNT: if (match) begin
          state_d = (LOCK_N == 3'd1) ? LOCKED : VERIFY;
          pos_d   = 5'd1;
          good_d  = 3'd1;
        end
        VERIFY: begin
          pos_d = pos_nx;
          if (at_tail) begin
            good_d  = match ? good_q + 3'd1 : 3'd0;
            state_d = !match ? HUNT : (good_q + 3'd1 == LOCK_N) ? LOCKED : VERIFY;
          end
        end
        LOCKED: begin
          pos_d  = pos_nx;
          fs_d   = pos_q ^ (pos_q >> 1);
          tail_d = at_tail;
          // flywheel: the tail is emitted even when its marker is bad
          if (at_tail && match) miss_d = 3'd0;
          else if (at_tail) begin
            err_d  = &err_q ? err_q : err_q + 16'd1;
            miss_d = miss_q + 3'd1;
            if (miss_q + 3'd1 == MISS_N) begin
              state_d = HUNT;
              miss_d  = 3'd0;
              good_d  = 3'd0;
            end
          end
        end
        default: state_d = HUNT;
      endcase
  end
  always_ff @(posedge clk_390p625M) begin
    if (rst) begin
      state_q <= HUNT;
      pos_q   <= '0;
      good_q  <= '0;
      miss_q  <= '0;
      err_q   <= '0;
      fs_q    <= '0;
      tail_q  <= 1'b0;
      lock_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      good_q  <= good_d;
      miss_q  <= miss_d;
      err_q   <= err_d;
      fs_q    <= fs_d;
      tail_q  <= tail_d;
      lock_q  <= state_d == LOCKED;
      data_q  <= data_d;
    end
  end
  assign bus.unscrambled_data = data_q;
  assign bus.frame_state      = fs_q;
  assign bus.frame_tail_flag  = tail_q;
  assign bus.frame_lock       = lock_q;
  assign bus.marker_err_cnt   = err_q;
endmodule
